// File: rtl/tick_bcd_counter_if.sv
// Control and data bundle for the prescaled BCD counter.
// master drives the controls; slave is the counter itself.
interface tick_bcd_counter_if #(
  parameter int DIGITS = 2
);
  logic                en;
  logic                up;
  logic                clear;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd_num;
  logic                tick;
  logic                carry;

  modport master (
    output en, up, clear, load, load_val,
    input  bcd_num, tick, carry
  );

  modport slave (
    input  en, up, clear, load, load_val,
    output bcd_num, tick, carry
  );
endinterface

// File: rtl/tick_bcd_counter.sv
// Prescaled multi-digit BCD up/down counter.
// A registered tick steps the count; carry flags wrap.
module tick_bcd_counter #(
  parameter int CLK_DIV = 24,
  parameter int DIGITS  = 2
) (
  input logic              clk,
  input logic              res,
  tick_bcd_counter_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int NB = 4 * DIGITS;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] ps_q;
  logic          tick_q;
  logic          carry_q;
  logic [NB-1:0] bcd_q;

  logic [NB-1:0] inc_val;
  logic [NB-1:0] dec_val;
  logic [NB-1:0] sat_val;
  logic [NB-1:0] step_val;
  logic [DIGITS:0] c_up;
  logic [DIGITS:0] c_dn;
  logic          ps_last;
  logic          wrap;

  assign c_up[0] = 1'b1;
  assign c_dn[0] = 1'b1;

  // Ripple chains: a digit moves only when all lower digits roll over.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] d;
    logic [3:0] l;

    assign d = bcd_q[4*g +: 4];
    assign l = bus.load_val[4*g +: 4];

    assign c_up[g+1] = c_up[g] & (d == 4'd9);
    assign c_dn[g+1] = c_dn[g] & (d == 4'd0);

    assign inc_val[4*g +: 4] =
      !c_up[g]     ? d     :
      (d == 4'd9)  ? 4'd0  :
                     d + 4'd1;

    assign dec_val[4*g +: 4] =
      !c_dn[g]     ? d     :
      (d == 4'd0)  ? 4'd9  :
                     d - 4'd1;

    assign sat_val[4*g +: 4] = (l > 4'd9) ? 4'd9 : l;
  end

  assign step_val = bus.up ? inc_val : dec_val;
  assign wrap     = bus.up ? c_up[DIGITS] : c_dn[DIGITS];
  assign ps_last  = (ps_q == PS_LAST);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else if (bus.clear || bus.load) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else if (bus.en) begin
      ps_q   <= ps_last ? '0 : ps_q + 1'b1;
      tick_q <= ps_last;
    end else begin
      tick_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      bcd_q   <= '0;
      carry_q <= 1'b0;
    end else if (bus.clear) begin
      bcd_q   <= '0;
      carry_q <= 1'b0;
    end else if (bus.load) begin
      bcd_q   <= sat_val;
      carry_q <= 1'b0;
    end else begin
      carry_q <= tick_q & wrap;
      if (tick_q) begin
        bcd_q <= step_val;
      end
    end
  end

  assign bus.bcd_num = bcd_q;
  assign bus.tick    = tick_q;
  assign bus.carry   = carry_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Randomised and directed bench for tick_bcd_counter.
// Decimal-arithmetic model checked every cycle.
module tb_tick_bcd_counter;

  localparam int CLK_DIV = 4;
  localparam int DIGITS  = 2;

  logic clk = 1'b0;
  logic res = 1'b1;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  tick_bcd_counter_if #(.DIGITS(DIGITS)) bif ();

  tick_bcd_counter #(
    .CLK_DIV(CLK_DIV),
    .DIGITS (DIGITS)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bif)
  );

  always #5 clk = ~clk;

  // Model state: count as a plain decimal integer 0..99.
  int m_val   = 0;
  int m_ph    = 0;
  bit m_tick  = 1'b0;
  bit m_carry = 1'b0;

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int sat_dec(logic [7:0] x);
    int hi;
    int lo;
    hi = int'(x[7:4]);
    lo = int'(x[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_val   <= 0;
      m_ph    <= 0;
      m_tick  <= 1'b0;
      m_carry <= 1'b0;
    end else if (bif.clear) begin
      m_val   <= 0;
      m_ph    <= 0;
      m_tick  <= 1'b0;
      m_carry <= 1'b0;
    end else if (bif.load) begin
      m_val   <= sat_dec(bif.load_val);
      m_ph    <= 0;
      m_tick  <= 1'b0;
      m_carry <= 1'b0;
    end else begin
      if (m_tick) begin
        if (bif.up) begin
          m_val   <= (m_val + 1) % 100;
          m_carry <= (m_val == 99);
        end else begin
          m_val   <= (m_val + 99) % 100;
          m_carry <= (m_val == 0);
        end
      end else begin
        m_carry <= 1'b0;
      end
      if (bif.en) begin
        m_tick <= (m_ph == CLK_DIV - 1);
        m_ph   <= (m_ph + 1) % CLK_DIV;
      end else begin
        m_tick <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      checks++;
      if (bif.bcd_num !== to_bcd(m_val)) begin
        failures++;
        $display("FAIL model_bcd t=%0t got=%h exp=%h",
                 $time, bif.bcd_num, to_bcd(m_val));
      end
      checks++;
      if (bif.tick !== m_tick) begin
        failures++;
        $display("FAIL model_tick t=%0t got=%b exp=%b",
                 $time, bif.tick, m_tick);
      end
      checks++;
      if (bif.carry !== m_carry) begin
        failures++;
        $display("FAIL model_carry t=%0t got=%b exp=%b",
                 $time, bif.carry, m_carry);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(logic [7:0] v);
    bif.load     = 1'b1;
    bif.load_val = v;
    edges(1);
    bif.load     = 1'b0;
  endtask

  initial begin
    bif.en       = 1'b0;
    bif.up       = 1'b1;
    bif.clear    = 1'b0;
    bif.load     = 1'b0;
    bif.load_val = '0;
    #1;
    run_cmp = 1'b1;
    edges(2);
    chk("reset_bcd",   32'(bif.bcd_num), 32'h00);
    chk("reset_tick",  32'(bif.tick),    32'h0);
    chk("reset_carry", 32'(bif.carry),   32'h0);

    // Free run after reset release.
    res    = 1'b0;
    bif.en = 1'b1;
    bif.up = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      edges(1);
      if (e == 4 || e == 8 || e == 12)
        chk($sformatf("run_tick_e%0d", e), 32'(bif.tick), 32'h1);
      if (e == 5)  chk("run_bcd_e5",  32'(bif.bcd_num), 32'h01);
      if (e == 9)  chk("run_bcd_e9",  32'(bif.bcd_num), 32'h02);
      if (e == 13) chk("run_bcd_e13", 32'(bif.bcd_num), 32'h03);
    end

    // Up wrap.
    do_load(8'h99);
    chk("load99", 32'(bif.bcd_num), 32'h99);
    edges(5);
    chk("upwrap_bcd",   32'(bif.bcd_num), 32'h00);
    chk("upwrap_carry", 32'(bif.carry),   32'h1);
    edges(1);
    chk("upwrap_carry_drop", 32'(bif.carry), 32'h0);
    edges(3);
    chk("upwrap_next_bcd",   32'(bif.bcd_num), 32'h01);
    chk("upwrap_next_carry", 32'(bif.carry),   32'h0);

    // Down wrap.
    bif.up = 1'b0;
    do_load(8'h00);
    edges(5);
    chk("dnwrap_bcd",   32'(bif.bcd_num), 32'h99);
    chk("dnwrap_carry", 32'(bif.carry),   32'h1);
    edges(4);
    chk("dnwrap_next_bcd",   32'(bif.bcd_num), 32'h98);
    chk("dnwrap_next_carry", 32'(bif.carry),   32'h0);

    // Saturating loads.
    do_load(8'h5C);
    chk("sat_5c", 32'(bif.bcd_num), 32'h59);
    do_load(8'h3F);
    chk("sat_3f", 32'(bif.bcd_num), 32'h39);
    bif.up = 1'b1;
    edges(5);
    chk("step_39_40", 32'(bif.bcd_num), 32'h40);

    // Priority: clear over load, load over step.
    bif.clear    = 1'b1;
    bif.load     = 1'b1;
    bif.load_val = 8'h77;
    edges(1);
    bif.clear = 1'b0;
    bif.load  = 1'b0;
    chk("clear_wins", 32'(bif.bcd_num), 32'h00);
    edges(4);
    chk("clear_restart_tick", 32'(bif.tick), 32'h1);
    do_load(8'h25);
    chk("load_drops_step", 32'(bif.bcd_num), 32'h25);
    chk("load_tick_zero",  32'(bif.tick),    32'h0);
    edges(4);
    chk("load_restart_tick", 32'(bif.tick), 32'h1);
    edges(1);
    chk("load_restart_bcd", 32'(bif.bcd_num), 32'h26);

    // Enable pause keeps phase.
    do_load(8'h10);
    edges(2);
    bif.en = 1'b0;
    edges(10);
    chk("pause_no_tick", 32'(bif.tick), 32'h0);
    bif.en = 1'b1;
    edges(2);
    chk("pause_resume_tick", 32'(bif.tick), 32'h1);
    edges(1);
    chk("pause_resume_bcd", 32'(bif.bcd_num), 32'h11);
    edges(1);

    // Asynchronous reset mid-period.
    #2;
    res = 1'b1;
    #1;
    chk("async_res_bcd",   32'(bif.bcd_num), 32'h00);
    chk("async_res_tick",  32'(bif.tick),    32'h0);
    chk("async_res_carry", 32'(bif.carry),   32'h0);
    edges(1);
    res = 1'b0;
    edges(3);
    chk("post_res_no_tick", 32'(bif.tick), 32'h0);
    edges(1);
    chk("post_res_tick", 32'(bif.tick), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bif.en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) bif.up = ~bif.up;
      bif.clear = ($urandom_range(0, 79) == 0);
      bif.load  = ($urandom_range(0, 29) == 0);
      bif.load_val = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        res = 1'b1;
        #1;
        chk("rand_async_res", 32'(bif.bcd_num), 32'h00);
        edges(1);
        res = 1'b0;
      end else begin
        edges(1);
      end
    end

    bif.clear = 1'b0;
    bif.load  = 1'b0;
    edges(2);
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 24, giving clock cycles per count step; legal range is 2 or more.
REQ-002 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits; legal range is 1 to 8.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port res, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, width 1: prescaler run enable.
REQ-006 The block SHALL have port up, input, width 1: count direction (1 = up, 0 = down).
REQ-007 The block SHALL have port clear, input, width 1: synchronous clear.
REQ-008 The block SHALL have port load, input, width 1: synchronous load strobe.
REQ-009 The block SHALL have port load_val, input, width 4*DIGITS: BCD load value; digit 0 is in bits [3:0].
REQ-010 The block SHALL have port bcd_num, output, width 4*DIGITS: registered BCD count value.
REQ-011 The block SHALL have port tick, output, width 1: registered one-cycle step pulse.
REQ-012 The block SHALL have port carry, output, width 1: registered one-cycle wrap pulse (carry when counting up, borrow when counting down).

Function
REQ-013 The prescaler SHALL be ceil(log2(CLK_DIV)) bits wide and count 0 to CLK_DIV-1 on each edge with en=1, then wrap to 0.
REQ-014 When en=0, the prescaler SHALL hold its value and no new tick SHALL be generated.
REQ-015 On the edge where the prescaler wraps from CLK_DIV-1 to 0 with en=1, tick SHALL go to 1; otherwise tick SHALL go to 0, so tick is never high for two consecutive cycles.
REQ-016 On each edge where tick=1, bcd_num SHALL step once in the direction given by up at that edge, regardless of en; the total latency is 2 cycles from the prescaler terminal value to the new bcd_num.
REQ-017 Up-count SHALL be a rippled BCD increment: a digit at 9 goes to 0 and increments the next digit; digits only ever hold 0 to 9.
REQ-018 Down-count SHALL be a rippled BCD decrement: a digit at 0 goes to 9 and borrows from the next digit.
REQ-019 Up-count wrap: when all digits are 9, bcd_num SHALL become all 0 and carry SHALL be 1 for exactly that cycle.
REQ-020 Down-count wrap: when all digits are 0, bcd_num SHALL become all 9 and carry SHALL be 1 for exactly that cycle.
REQ-021 carry SHALL be 0 in every cycle other than a wrap step.
REQ-022 Priority SHALL be clear > load > tick step.
REQ-023 clear=1 SHALL set the prescaler, tick, carry and bcd_num to 0 on that edge.
REQ-024 load=1 (with clear=0) SHALL set bcd_num to load_val, zero the prescaler and set tick and carry to 0; a coincident tick step is discarded.
REQ-025 On load, any load_val digit greater than 9 SHALL be loaded as 9; the other digits are loaded unchanged.
REQ-026 A change of up between ticks SHALL take effect on the next step only; there is no other side effect.
REQ-027 A load or clear SHALL restart the full CLK_DIV period: the next tick arrives CLK_DIV edges later, with en held at 1.

Reset
REQ-028 While res=1, the prescaler, tick, carry and bcd_num SHALL be 0 immediately, independent of clk.
REQ-029 Reset assertion mid-period or mid-pulse SHALL abort all activity; no step or pulse completes after reset.
REQ-030 After res is released, the first tick SHALL occur on the CLK_DIV-th edge with en=1.

Verification
All scenarios use CLK_DIV=4 and DIGITS=2.
REQ-031 Release res, hold en=1 and up=1 -> tick is high after edges 4, 8 and 12; bcd_num goes 0x01 at edge 5, 0x02 at edge 9 and 0x03 at edge 13.
REQ-032 Load 0x99 with up=1, run to the next step -> bcd_num=0x00 and carry=1 for one cycle; on the following step bcd_num=0x01 and carry=0.
REQ-033 Load 0x00 with up=0 -> the first step gives bcd_num=0x99 and carry=1; the next step gives 0x98.
REQ-034 Load 0x5C, then 0x3F -> bcd_num is 0x59, then 0x39; with up=1, 0x39 steps to 0x40.
REQ-035 Assert clear and load together, then load in the same cycle as tick=1 -> clear wins (bcd_num=0x00); the load value is taken and the step is dropped.
REQ-036 Drop en for 10 cycles mid-period, then assert res mid-period -> the tick phase resumes unchanged after en returns; res zeroes all outputs asynchronously.
